// File: rtl/bcx_work_dispatcher_pkg.sv
// -----------------------------------------------------------------------------
// bcx_work_dispatcher_pkg
// Shared types and constants for the work dispatcher and the processor chain.
//   HashState          : SHA-256 midstate words a..h (a is the most significant)
//   disp_state_e       : dispatcher FSM states
//   BCX_CHAIN_LATENCY  : cycles from an iteration issue to its victory report,
//                        the chain top and the dispatcher must agree on it
//   LOAD_WORDS         : words in one host job (8 midstate + 3 tail)
// -----------------------------------------------------------------------------
package bcx_work_dispatcher_pkg;

  localparam int unsigned BCX_CHAIN_LATENCY = 130;
  localparam int unsigned LOAD_WORDS        = 11;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } HashState;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_RUN,
    ST_DRAIN,
    ST_REPORT
  } disp_state_e;

endpackage

// File: rtl/bcx_job_loader.sv
// -----------------------------------------------------------------------------
// bcx_job_loader
// Collects the 11 host load words of one job into registers and presents them
// as the midstate and tail words for processor 0.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_ld_valid   : host word valid
//   i_ld_en      : dispatcher is willing to accept (its ld_ready)
//   i_ld_data    : host word; order a..h, then Words[0..2]
//   o_hashstate  : registered midstate
//   o_words      : registered tail words
//   o_load_done  : accept of the final (11th) word this cycle
// -----------------------------------------------------------------------------
module bcx_job_loader
  import bcx_work_dispatcher_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_ld_valid,
  input  logic             i_ld_en,
  input  logic [31:0]      i_ld_data,
  output HashState         o_hashstate,
  output logic [2:0][31:0] o_words,
  output logic             o_load_done
);

  localparam logic [3:0] LAST_IDX = 4'(LOAD_WORDS - 1);

  logic [3:0]  r_idx;
  logic [31:0] r_word [LOAD_WORDS];
  logic        w_accept;

  assign w_accept    = i_ld_valid && i_ld_en;
  assign o_load_done = w_accept && (r_idx == LAST_IDX);

  // Each word is overwritten only when its own slot is reloaded, so the
  // outputs stay stable for the whole job.
  // NOTE: this small register file is reset on purpose, since the outputs must
  // read zero after reset; a large RAM would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      for (int i = 0; i < LOAD_WORDS; i++) r_word[i] <= '0;
    end else if (w_accept) begin
      r_word[r_idx] <= i_ld_data;
      r_idx         <= (r_idx == LAST_IDX) ? '0 : r_idx + 4'd1;
    end
  end

  assign o_hashstate = '{a: r_word[0], b: r_word[1], c: r_word[2], d: r_word[3],
                         e: r_word[4], f: r_word[5], g: r_word[6], h: r_word[7]};
  assign o_words[0]  = r_word[8];
  assign o_words[1]  = r_word[9];
  assign o_words[2]  = r_word[10];

endmodule

// File: rtl/bcx_work_dispatcher.sv
// -----------------------------------------------------------------------------
// bcx_work_dispatcher
// Head and tail controller of the standard processor chain. Loads one job from
// the host, issues one iteration per cycle to processor 0 (newblock on the
// first), watches the chain end for a victory and reports the winning nonce.
//   clk, rst        : clock, asynchronous active-low reset
//   ld_valid_i/ld_ready_o/ld_data_i : host job load handshake (11 words)
//   valid_o         : iteration valid to processor 0
//   newblock_o      : first iteration of a job
//   hashstate_o     : midstate to processor 0
//   Words_o         : tail words to processor 0
//   victory_i       : success from the chain end
//   nonce_start_i   : winning processor index from the chain end
//   found_o/done_o/nonce_o : result to host
//   res_ack_i       : host consumed the result
// -----------------------------------------------------------------------------
module bcx_work_dispatcher
  import bcx_work_dispatcher_pkg::*;
#(
  parameter int unsigned PARTITIONBITS = 1,
  parameter int unsigned ITERBITS      = 32 - PARTITIONBITS,
  parameter int unsigned CHAIN_LATENCY = BCX_CHAIN_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid_i,
  output logic                     ld_ready_o,
  input  logic [31:0]              ld_data_i,
  output logic                     valid_o,
  output logic                     newblock_o,
  output HashState                 hashstate_o,
  output logic [2:0][31:0]         Words_o,
  input  logic                     victory_i,
  input  logic [PARTITIONBITS-1:0] nonce_start_i,
  output logic                     found_o,
  output logic                     done_o,
  output logic [31:0]              nonce_o,
  input  logic                     res_ack_i
);

  // Elapsed counter is wide enough to reach last issue + chain latency
  // without wrapping.
  localparam int unsigned EW = ITERBITS + $clog2(CHAIN_LATENCY) + 1;

  localparam logic [ITERBITS-1:0] ITER_MAX  = '1;
  localparam logic [EW-1:0]       LAST_E    = EW'(ITER_MAX);
  localparam logic [EW-1:0]       DRAIN_END = LAST_E + EW'(CHAIN_LATENCY);

  disp_state_e         r_state;
  disp_state_e         w_state_next;
  logic [ITERBITS-1:0] r_iter;
  logic [EW-1:0]       r_elapsed;
  logic                r_found;
  logic                r_done;
  logic [31:0]         r_nonce;

  logic                w_ld_ready;
  logic                w_load_done;
  logic                w_valid;
  logic                w_newblock;
  logic                w_capture;
  logic                w_expire;
  logic [ITERBITS-1:0] w_win_idx;
  logic [31:0]         w_nonce;

  // Ready depends only on the registered state, so the loader's load_done
  // cannot feed back into it combinationally.
  assign w_ld_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD);

  bcx_job_loader u_loader (
    .clk         (clk),
    .rst_n       (rst),
    .i_ld_valid  (ld_valid_i),
    .i_ld_en     (w_ld_ready),
    .i_ld_data   (ld_data_i),
    .o_hashstate (hashstate_o),
    .o_words     (Words_o),
    .o_load_done (w_load_done)
  );

  // A victory seen now belongs to the iteration issued CHAIN_LATENCY cycles
  // ago; the processor index supplies the high nonce bits.
  assign w_win_idx = ITERBITS'(r_elapsed - EW'(CHAIN_LATENCY));
  assign w_nonce   = 32'({nonce_start_i, w_win_idx});

  // NOTE: every signal written here gets a default first so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    w_newblock   = 1'b0;
    w_capture    = 1'b0;
    w_expire     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (ld_valid_i) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_load_done) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        w_valid      = 1'b1;
        w_newblock   = 1'b1;
        w_state_next = (r_iter == ITER_MAX) ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        w_valid = 1'b1;
        // Victory takes priority over the move to DRAIN.
        if (victory_i) begin
          w_capture    = 1'b1;
          w_state_next = ST_REPORT;
        end else if (r_iter == ITER_MAX) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last iteration's victory can still arrive on the expiry cycle.
        if (victory_i) begin
          w_capture    = 1'b1;
          w_state_next = ST_REPORT;
        end else if (r_elapsed == DRAIN_END) begin
          w_expire     = 1'b1;
          w_state_next = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (res_ack_i) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_iter    <= '0;
      r_elapsed <= '0;
      r_found   <= 1'b0;
      r_done    <= 1'b0;
      r_nonce   <= '0;
    end else begin
      r_state <= w_state_next;

      unique case (r_state)
        ST_LOAD: begin
          if (w_load_done) begin
            r_iter    <= '0;
            r_elapsed <= '0;
          end
        end
        ST_ISSUE, ST_RUN: begin
          r_iter    <= r_iter + 1'b1;
          r_elapsed <= r_elapsed + 1'b1;
        end
        ST_DRAIN: r_elapsed <= r_elapsed + 1'b1;
        default: ;
      endcase

      if (w_capture) begin
        r_found <= 1'b1;
        r_done  <= 1'b1;
        r_nonce <= w_nonce;
      end else if (w_expire) begin
        r_done  <= 1'b1;
      end else if ((r_state == ST_REPORT) && res_ack_i) begin
        r_found <= 1'b0;
        r_done  <= 1'b0;
        r_nonce <= '0;
      end
    end
  end

  assign ld_ready_o = w_ld_ready;
  assign valid_o    = w_valid;
  assign newblock_o = w_newblock;
  assign found_o    = r_found;
  assign done_o     = r_done;
  assign nonce_o    = r_nonce;

endmodule

// File: doc/bcx_work_dispatcher.md
Name: bcx_work_dispatcher

Overview:
- Head-and-tail controller for the standard processor chain.
- Accepts one block job from the host: 8-word SHA midstate plus 3 tail words.
- Presents the job to the first standard processor with a one-cycle newblock marker, then holds valid for one cycle per nonce iteration.
- Consumes victory/nonce_start from the chain's last processor and reconstructs the winning 32-bit nonce for the host.

Parameters:
PARTITIONBITS, 1, width of nonce_start; number of high nonce bits selected by processor index
ITERBITS, 32-PARTITIONBITS, low nonce bits swept per job; bench may shrink (e.g. 4)
CHAIN_LATENCY, 130, cycles from a valid_o issue to victory_i for that same iteration (includes full chain plus validator)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
ld_valid_i  in  1  host load word valid
ld_ready_o  out  1  dispatcher accepts load word
ld_data_i  in  32  load word: index 0-7 = hashstate a..h, 8-10 = Words[0..2]
valid_o  out  1  iteration valid to processor 0
newblock_o  out  1  first iteration of a new job
hashstate_o  out  HashState  midstate to processor 0
Words_o  out  3x32  tail words to processor 0
victory_i  in  1  success from chain end
nonce_start_i  in  PARTITIONBITS  winning processor index from chain end
found_o  out  1  result: winning nonce valid
done_o  out  1  result available (found or exhausted)
nonce_o  out  32  winning nonce
res_ack_i  in  1  host consumed result

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; hashstate_o/Words_o 0; load index 0; counters 0.
- Load handshake: a word is accepted when ld_valid_i && ld_ready_o.
  - ld_ready_o = 1 only in IDLE and LOAD.
  - Words land in order: hashstate a..h, then Words[0..2].
- FSM states and transitions:
  - IDLE: first accepted word -> LOAD (load index 1).
  - LOAD: after the accept of word 10 -> ISSUE next cycle.
  - ISSUE: exactly one cycle. valid_o = 1, newblock_o = 1; iteration counter starts at 0; elapsed counter cleared.
  - RUN:
    - valid_o = 1 every cycle; iteration counter +1 per cycle.
    - When the iteration issued equals 2^ITERBITS-1 -> DRAIN next cycle.
    - If ITERBITS iterations = 1, go ISSUE -> DRAIN.
  - DRAIN:
    - valid_o = 0; elapsed counter keeps running.
    - When elapsed = last-issue cycle + CHAIN_LATENCY with no victory -> REPORT, found_o = 0, done_o = 1.
  - REPORT:
    - done_o = 1 and nonce_o/found_o held stable.
    - res_ack_i -> IDLE next cycle; outputs cleared except hashstate_o/Words_o.
- Elapsed counter:
  - Free-runs from the ISSUE cycle (value 0) through RUN and DRAIN.
  - Width ITERBITS + clog2(CHAIN_LATENCY) + 1; no wrap.
- Victory handling:
  - Active only in RUN/DRAIN; victory_i in other states is ignored.
  - On victory in RUN/DRAIN: winning index = elapsed - CHAIN_LATENCY.
  - nonce_o = {nonce_start_i, index[ITERBITS-1:0]}, zero-extended to 32 when PARTITIONBITS+ITERBITS < 32.
  - found_o = 1, done_o = 1, valid_o drops the same edge, state -> REPORT.
  - Only the first victory is captured; later victory_i is ignored.
- Simultaneous events:
  - Victory on the cycle RUN would go to DRAIN: victory wins -> REPORT.
  - Victory on the DRAIN expiry cycle: victory wins.
- Output stability: hashstate_o/Words_o registered at load, stable from ISSUE until the next job's corresponding word is accepted.
- No new load is accepted during ISSUE/RUN/DRAIN/REPORT.
- Reset mid-operation: immediate abort, all outputs 0, no result reported.

Decomposition:
- Shared package: HashState typedef (a..h, 32 bits each, 256 total) and dispatcher state enum (IDLE, LOAD, ISSUE, RUN, DRAIN, REPORT).
- Package also holds CHAIN_LATENCY as the chain-level constant, so the dispatcher and chain top agree.
- One natural sub-module: bcx_job_loader.
  - Contents: 11-word load shift/index register producing hashstate/Words and a load_done pulse.
  - FSM, counters and result capture stay in the top.

Test Plan:
1. Reset mid-RUN (ITERBITS=4) -> valid_o, newblock_o, found_o, done_o all 0 in the same cycle; ld_ready_o = 1 after reset release.
2. Load 11 words with ld_valid_i toggling every other cycle -> ld_ready_o low after word 10.
   - hashstate_o.a = word0, Words_o[2] = word10.
   - Exactly one newblock_o cycle, coincident with the first valid_o.
3. ITERBITS=4, CHAIN_LATENCY=8, no victory:
   - valid_o high for exactly 16 consecutive cycles.
   - done_o=1, found_o=0 asserted 8 cycles after the last valid_o issue.
4. ITERBITS=4, CHAIN_LATENCY=8, PARTITIONBITS=1, victory_i with nonce_start_i=1 at elapsed=13:
   - nonce_o = 0x15 (index 5 with bit 4 set).
   - found_o = done_o = 1; valid_o low the next cycle.
5. Victory at elapsed=20 (DRAIN) -> nonce_o low bits = 12.
   - A second victory_i 2 cycles later leaves nonce_o unchanged.
6. Victory on the final RUN cycle -> REPORT with found_o=1, no DRAIN visited.
   - res_ack_i -> IDLE next cycle; done_o=0, ld_ready_o=1.
